// File: rtl/sort_frame_loader.sv
// sort_frame_loader
//   Collects four serial two's-complement bytes into a registered frame that
//   drives the i1..i4 inputs of a downstream 4-input sorter. After the fourth
//   byte the loader waits SORT_LAT cycles for the sorter outputs to settle.
//   It then presents result_valid until the consumer acknowledges.
//
//   Parameters:
//     SORT_LAT      sorter settle latency in cycles, legal range 1..15
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous active-high reset
//     in_data       serial sample byte
//     in_valid      in_data valid
//     in_ready      loader accepts a sample this cycle (FILL and not in reset)
//     i1..i4        registered frame, bytes 1..4 in arrival order
//     result_valid  sorter outputs are valid for the held frame
//     result_ack    consumer has taken the sorter outputs
//     fill_cnt      samples accepted in the current frame
//     frame_cnt     completed frames
//   Build option:
//     SORT_FRAME_LOADER_FRAME_CNT_EN  when defined, frame_cnt counts acknowledged
//                                     frames and wraps at 16 bits; when undefined,
//                                     frame_cnt is tied to zero.
module sort_frame_loader #(
    parameter int unsigned SORT_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  i1,
    output logic [7:0]  i2,
    output logic [7:0]  i3,
    output logic [7:0]  i4,
    output logic        result_valid,
    input  logic        result_ack,
    output logic [1:0]  fill_cnt,
    output logic [15:0] frame_cnt
);

    localparam logic [3:0] LAT4 = 4'(SORT_LAT);

    typedef enum logic [1:0] {
        FILL,
        SETTLE,
        PRESENT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] fill_cnt_q, fill_cnt_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] i1_q, i1_d;
    logic [7:0] i2_q, i2_d;
    logic [7:0] i3_q, i3_d;
    logic [7:0] i4_q, i4_d;

    // State register plus frame datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            settle_q   <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            i3_q       <= '0;
            i4_q       <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            settle_q   <= settle_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            i3_q       <= i3_d;
            i4_q       <= i4_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (in_valid && fill_cnt_q == 2'd3) state_d = SETTLE;
            // Leave on the edge where the counter steps 1 -> 0, giving
            // exactly SORT_LAT cycles in SETTLE.
            SETTLE:  if (settle_q <= 4'd1) state_d = PRESENT;
            PRESENT: if (result_ack) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Frame capture and settle countdown.
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        settle_d   = settle_q;
        i1_d       = i1_q;
        i2_d       = i2_q;
        i3_d       = i3_q;
        i4_d       = i4_q;
        if (state_q == FILL && in_valid) begin
            unique case (fill_cnt_q)
                2'd0: i1_d = in_data;
                2'd1: i2_d = in_data;
                2'd2: i3_d = in_data;
                2'd3: i4_d = in_data;
            endcase
            // 2-bit counter wraps 3 -> 0 on the fourth transfer.
            fill_cnt_d = fill_cnt_q + 2'd1;
            if (fill_cnt_q == 2'd3) settle_d = LAT4;
        end
        if (state_q == SETTLE) settle_d = settle_q - 4'd1;
    end

    // Outputs decode from registered state; in_ready is also held low in reset.
    always_comb begin
        in_ready     = (state_q == FILL) && !rst;
        result_valid = (state_q == PRESENT);
        fill_cnt     = fill_cnt_q;
        i1           = i1_q;
        i2           = i2_q;
        i3           = i3_q;
        i4           = i4_q;
    end

`ifdef SORT_FRAME_LOADER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == PRESENT && result_ack) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
